// File: rtl/boot_loader_pkg.sv
// Shared definitions for the word-stream program loader: default widths,
// the frame start word and the loader state encoding.
package boot_loader_pkg;

    localparam int              WORD_WIDTH_DEF    = 16;
    localparam int              RAMADDR_WIDTH_DEF = 8;
    localparam logic [15:0]     MAGIC_DEF         = 16'hB007;

    // Encodings are fixed so they line up with the rest of the core.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

    // States in which a frame is in flight and the loader owns the RAM port.
    function automatic logic is_loading(input state_e s);
        return (s == ST_ADDR) || (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Stream input handshake plus the RAM write port driven by the loader.
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int RAMADDR_WIDTH = RAMADDR_WIDTH_DEF
);
    logic                     InValid;
    logic                     InReady;
    logic [WORD_WIDTH-1:0]    InData;
    logic                     RamWriteEnable;
    logic [RAMADDR_WIDTH-1:0] RamWriteAddr;
    logic [WORD_WIDTH-1:0]    RamWriteData;

    // Loader side: consumes the stream, drives the RAM write port.
    modport slave (
        input  InValid,
        input  InData,
        output InReady,
        output RamWriteEnable,
        output RamWriteAddr,
        output RamWriteData
    );

    // Source side: produces the stream, observes the RAM write port.
    modport master (
        output InValid,
        output InData,
        input  InReady,
        input  RamWriteEnable,
        input  RamWriteAddr,
        input  RamWriteData
    );
endinterface

// File: rtl/boot_loader.sv
// Word-stream program loader. Parses MAGIC / StartAddr / Count / data /
// checksum frames, writes the data words into RAM and releases the core
// only after the checksum verifies.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                    WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int                    RAMADDR_WIDTH = RAMADDR_WIDTH_DEF,
    parameter logic [WORD_WIDTH-1:0] MAGIC         = MAGIC_DEF
)(
    input  logic          gclk,
    input  logic          PowerOn,
    boot_loader_if.slave  bus,
    output logic          LoadActive,
    output logic          CoreHold,
    output logic          Done,
    output logic          Error
);

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic [RAMADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]    sum_q, sum_d;
    logic [WORD_WIDTH-1:0]    remaining_q, remaining_d;
    logic                     we_q, we_d;
    logic [RAMADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     core_hold_q, core_hold_d;

    logic accept;
    assign accept = bus.InValid & in_ready_q;

    // Next-state and next-output logic: one accepted word advances the frame parser.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        in_ready_d  = 1'b1;
        addr_d      = addr_q;
        sum_d       = sum_q;
        remaining_d = remaining_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        core_hold_d = core_hold_q;

        if (accept) begin
            case (state_q)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    // Non-MAGIC words are dropped; MAGIC starts a new frame.
                    if (bus.InData == MAGIC) begin
                        state_d     = ST_ADDR;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                        core_hold_d = 1'b1;
                    end
                end
                ST_ADDR: begin
                    addr_d  = bus.InData[RAMADDR_WIDTH-1:0];
                    sum_d   = bus.InData;
                    state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (bus.InData == '0) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        remaining_d = bus.InData;
                        sum_d       = sum_q + bus.InData;
                        state_d     = ST_DATA;
                    end
                end
                ST_DATA: begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = bus.InData;
                    addr_d      = addr_q + 1'b1;
                    sum_d       = sum_q + bus.InData;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == WORD_WIDTH'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (bus.InData == sum_q) begin
                        state_d     = ST_RUN;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-high PowerOn.
    always_ff @(posedge gclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (PowerOn) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            addr_q      <= '0;
            sum_q       <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            remaining_q <= remaining_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_hold_q <= core_hold_d;
        end
    end

    assign bus.InReady        = in_ready_q;
    assign bus.RamWriteEnable = we_q;
    assign bus.RamWriteAddr   = waddr_q;
    assign bus.RamWriteData   = wdata_q;

    // The loader keeps the RAM port through the trailing cycle of its last write.
    assign LoadActive = is_loading(state_q) | we_q;
    assign CoreHold   = core_hold_q;
    assign Done       = done_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected RAM writes are queued as
// data beats are driven and popped when the write strobe appears.
module tb_boot_loader;
    import boot_loader_pkg::*;

    logic gclk;
    logic PowerOn;
    logic LoadActive, CoreHold, Done, Error;

    boot_loader_if #(.WORD_WIDTH(16), .RAMADDR_WIDTH(8)) bus ();

    boot_loader #(.WORD_WIDTH(16), .RAMADDR_WIDTH(8), .MAGIC(16'hB007)) dut (
        .gclk       (gclk),
        .PowerOn    (PowerOn),
        .bus        (bus.slave),
        .LoadActive (LoadActive),
        .CoreHold   (CoreHold),
        .Done       (Done),
        .Error      (Error)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    always @(posedge gclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every observed write must match the oldest expected one.
    always @(negedge gclk) begin
        if (bus.RamWriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", {24'd0, bus.RamWriteAddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {24'd0, bus.RamWriteAddr}, {24'd0, e.addr});
                check("wr_data", {16'd0, bus.RamWriteData}, {16'd0, e.data});
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one word and wait for it to be accepted; data beats queue an expected write.
    task automatic send_word(input logic [15:0] w, input bit is_data, input logic [7:0] a);
        int n;
        n = 0;
        bus.InValid = 1'b1;
        bus.InData  = w;
        @(negedge gclk);
        while (bus.InReady !== 1'b1 && n < 20) begin
            n++;
            @(negedge gclk);
        end
        if (bus.InReady !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        @(posedge gclk);
        #1;
        bus.InValid = 1'b0;
        if (is_data) sb.push_back('{addr: a, data: w, cyc: cyc});
    endtask

    task automatic idle(input int n);
        bus.InValid = 1'b0;
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"}, {31'd0, Done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, Error}, {31'd0, e});
        check({tag, "_hold"}, {31'd0, CoreHold}, {31'd0, h});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.InReady}, 32'd0);
        check({tag, "_we"}, {31'd0, bus.RamWriteEnable}, 32'd0);
        check({tag, "_waddr"}, {24'd0, bus.RamWriteAddr}, 32'd0);
        check({tag, "_wdata"}, {16'd0, bus.RamWriteData}, 32'd0);
        check({tag, "_active"}, {31'd0, LoadActive}, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1);
    endtask

    // Frame with start address a, data words in d[0..n-1], checksum cs.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [15:0] cs, input int gap);
        logic [15:0] dw [3];
        logic [7:0]  wa;
        dw[0] = d0; dw[1] = d1; dw[2] = d2;
        wa = a[7:0];
        send_word(16'hB007, 1'b0, 8'd0);
        if (gap > 0) idle(gap);
        send_word(a, 1'b0, 8'd0);
        if (gap > 0) idle(gap);
        send_word(n, 1'b0, 8'd0);
        for (int i = 0; i < int'(n); i++) begin
            if (gap > 0) idle(gap);
            send_word(dw[i], 1'b1, wa);
            wa = wa + 8'd1;
        end
        if (gap > 0) idle(gap);
        send_word(cs, 1'b0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        PowerOn     = 1'b1;
        bus.InValid = 1'b0;
        bus.InData  = 16'h0000;
        repeat (3) @(posedge gclk);
        #1;
        check_reset_outputs("reset");
        PowerOn = 1'b0;
        @(posedge gclk);
        #1;
        check("ready_after_reset", {31'd0, bus.InReady}, 32'd1);

        // Normal load.
        send_frame(16'h0001, 16'h0003, 16'h00C2, 16'h0001, 16'h0002, 16'h00C9, 0);
        check_status("normal", 1'b1, 1'b0, 1'b0);
        check("normal_active", {31'd0, LoadActive}, 32'd0);
        idle(2);
        check("normal_sb", sb.size(), 32'd0);

        // Bad checksum, then a good frame clears Error.
        send_frame(16'h0001, 16'h0003, 16'h00C2, 16'h0001, 16'h0002, 16'h00C8, 0);
        check_status("badcs", 1'b0, 1'b1, 1'b1);
        idle(2);
        send_word(16'hB007, 1'b0, 8'd0);
        check_status("err_magic", 1'b0, 1'b0, 1'b1);
        check("err_magic_active", {31'd0, LoadActive}, 32'd1);
        send_word(16'h0001, 1'b0, 8'd0);
        send_word(16'h0003, 1'b0, 8'd0);
        send_word(16'h00C2, 1'b1, 8'h01);
        send_word(16'h0001, 1'b1, 8'h02);
        send_word(16'h0002, 1'b1, 8'h03);
        send_word(16'h00C9, 1'b0, 8'd0);
        check_status("recover", 1'b1, 1'b0, 1'b0);
        idle(2);
        check("recover_sb", sb.size(), 32'd0);

        // Junk word, then zero count (from RUN the junk is dropped as well).
        PowerOn = 1'b1;
        idle(1);
        PowerOn = 1'b0;
        idle(1);
        send_word(16'h1234, 1'b0, 8'd0);
        check("junk_active", {31'd0, LoadActive}, 32'd0);
        check_status("junk", 1'b0, 1'b0, 1'b1);
        send_word(16'hB007, 1'b0, 8'd0);
        send_word(16'h0010, 1'b0, 8'd0);
        send_word(16'h0000, 1'b0, 8'd0);
        check_status("zero_n", 1'b0, 1'b1, 1'b1);
        check("zero_n_active", {31'd0, LoadActive}, 32'd0);
        idle(2);

        // Address wrap with 3-cycle stalls between beats.
        send_frame(16'h00FF, 16'h0002, 16'hAAAA, 16'h5555, 16'h0000, 16'h0100, 3);
        check_status("wrap", 1'b1, 1'b0, 1'b0);
        idle(2);
        check("wrap_sb", sb.size(), 32'd0);

        // Reset after the second data word of a 4-word frame.
        send_word(16'hB007, 1'b0, 8'd0);
        send_word(16'h0020, 1'b0, 8'd0);
        send_word(16'h0004, 1'b0, 8'd0);
        send_word(16'h1111, 1'b1, 8'h20);
        send_word(16'h2222, 1'b1, 8'h21);
        PowerOn = 1'b1;
        idle(1);
        check_reset_outputs("midreset");
        PowerOn = 1'b0;
        check("midreset_ready_low", {31'd0, bus.InReady}, 32'd0);
        idle(1);
        check("midreset_ready", {31'd0, bus.InReady}, 32'd1);
        send_word(16'h3333, 1'b0, 8'd0);
        send_word(16'h4444, 1'b0, 8'd0);
        check("midreset_active", {31'd0, LoadActive}, 32'd0);
        check_status("midreset_after", 1'b0, 1'b0, 1'b1);
        idle(2);
        check("midreset_sb", sb.size(), 32'd0);

        // MAGIC as payload inside a frame.
        send_frame(16'h0040, 16'h0002, 16'hB007, 16'h0005, 16'h0000, 16'hB04E, 0);
        check_status("magic_payload", 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reload from RUN.
        send_word(16'hB007, 1'b0, 8'd0);
        check_status("reload_magic", 1'b0, 1'b0, 1'b1);
        send_word(16'h0050, 1'b0, 8'd0);
        send_word(16'h0001, 1'b0, 8'd0);
        check("reload_mid_done", {31'd0, Done}, 32'd0);
        send_word(16'h1234, 1'b1, 8'h50);
        send_word(16'h1285, 1'b0, 8'd0);
        check_status("reload", 1'b1, 1'b0, 1'b0);
        idle(3);
        check("final_sb", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
